// File: rtl/sync_fifo_reader_if.sv
// Bus between sync_fifo_reader, its SyncFifo read port and the downstream consumer.
// Stream handshake: a word moves when m_valid & m_ready are both high on a rising
// clk edge; once m_valid is raised, m_valid and m_data stay stable until that edge.
interface sync_fifo_reader_if #(
    parameter int WIDTH = 64
);
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_ren;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        input  m_ready,
        output fifo_ren,
        output m_valid,
        output m_data
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        output m_ready,
        input  fifo_ren,
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/sync_fifo_reader.sv
// Drains a SyncFifo read port into a valid/ready stream through a 2-entry skid buffer.
// Optional SYNC_FIFO_READER_STATS_EN adds words_out / stall_cycles counters.
module sync_fifo_reader #(
    parameter int WIDTH        = 64,
    parameter int READ_LATENCY = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   flush,
    sync_fifo_reader_if.master     bus,
    output logic                   busy
`ifdef SYNC_FIFO_READER_STATS_EN
    ,
    output logic [31:0]            words_out,
    output logic [31:0]            stall_cycles
`endif
);

    logic [WIDTH-1:0] buf_q [2];
    logic [WIDTH-1:0] buf_n [2];
    logic [1:0]       occ;
    logic [1:0]       occ_n;
    logic             inflight;
    logic             inflight_n;
    logic             rd_ptr;
    logic             rd_n;
    logic             wr_ptr;
    logic             wr_n;
    logic             pop;
    logic             ren;
    logic             wr_en;
    logic [2:0]       room;

    assign pop  = bus.m_valid & bus.m_ready;
    // Slots committed after this edge: stored words plus an outstanding read, minus the pop.
    assign room = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    assign ren  = reset & enable & ~bus.fifo_empty & ~flush & (room < 3'd2);
    assign bus.fifo_ren = ren;

    // Fall-through FIFOs deliver on the ren edge; registered ones one edge later.
    assign wr_en = (READ_LATENCY == 0) ? ren : inflight;

    always_comb begin
        buf_n      = buf_q;
        occ_n      = occ;
        rd_n       = rd_ptr;
        wr_n       = wr_ptr;
        inflight_n = (READ_LATENCY != 0) & ren;
        if (flush) begin
            occ_n      = 2'd0;
            inflight_n = 1'b0;
            rd_n       = 1'b0;
            wr_n       = 1'b0;
        end else begin
            if (wr_en) begin
                buf_n[wr_ptr] = bus.fifo_dout;
                wr_n          = ~wr_ptr;
            end
            if (pop) begin
                rd_n = ~rd_ptr;
            end
            occ_n = occ + {1'b0, wr_en} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_q[0]    <= '0;
            buf_q[1]    <= '0;
            occ         <= 2'd0;
            inflight    <= 1'b0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            bus.m_valid <= 1'b0;
            bus.m_data  <= '0;
            busy        <= 1'b0;
        end else begin
            buf_q[0]    <= buf_n[0];
            buf_q[1]    <= buf_n[1];
            occ         <= occ_n;
            inflight    <= inflight_n;
            rd_ptr      <= rd_n;
            wr_ptr      <= wr_n;
            bus.m_valid <= (occ_n != 2'd0);
            bus.m_data  <= buf_n[rd_n];
            busy        <= (occ_n != 2'd0) | inflight_n;
        end
    end

`ifdef SYNC_FIFO_READER_STATS_EN
    // Statistics survive flush; only reset clears them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            words_out    <= 32'd0;
            stall_cycles <= 32'd0;
        end else begin
            if (pop) begin
                words_out <= words_out + 32'd1;
            end
            if (bus.m_valid && !bus.m_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
`else
    // Without statistics the stream core above is the whole block.
`endif

endmodule

// File: doc/sync_fifo_reader.md
Name: sync_fifo_reader

Overview:
Read-side drain engine for the team's SyncFifo (WIDTH/DEPTH synchronous FIFO with wen/ren/din/dout/full/empty).
- Pops words from the FIFO read port and presents them on a valid/ready stream toward downstream logic.
- Absorbs the FIFO read latency with a 2-entry output skid buffer, so the stream sustains one word per cycle with back-pressure.
- Sits between SyncFifo and any consumer; it is the counterpart of the producer logic that drives wen/din.

Parameters:
WIDTH, 64, data width; must match the attached SyncFifo.
READ_LATENCY, 0, cycles from ren sample to fifo_dout valid: 0 = fall-through (dout is head while !empty), 1 = registered dout.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset.
enable  input  1  when 0, no new FIFO reads; buffered words still drain.
flush  input  1  synchronous clear of skid buffer and in-flight read.
fifo_empty  input  1  SyncFifo empty.
fifo_dout  input  WIDTH  SyncFifo dout.
fifo_ren  output  1  SyncFifo ren.
m_valid  output  1  stream word valid.
m_ready  input  1  downstream accepts.
m_data  output  WIDTH  stream data.
busy  output  1  occ != 0 or read in flight.

Behaviour:
- Reset (reset==0, asynchronous): occ=0, inflight=0, buffer pointers=0, m_valid=0, m_data=0, fifo_ren=0, busy=0; stats counters=0 when compiled in.
- Internal state:
  - 2-entry buffer, occ in {0,1,2}, one read pointer, one write pointer.
  - inflight flag, used only when READ_LATENCY=1.
- pop = m_valid & m_ready.
- fifo_ren is combinational: enable & !fifo_empty & !flush & (occ + inflight - pop < 2).
- READ_LATENCY=0: on an edge with fifo_ren=1, fifo_dout is written into the buffer in the same cycle. m_valid rises on the next cycle (1-cycle latency).
- READ_LATENCY=1: fifo_ren=1 sets inflight; on the following edge fifo_dout is written and inflight clears, unless ren is re-issued. m_valid rises 2 cycles after ren.
- m_valid = (occ != 0); m_data = buffer[rd_ptr], registered. Once m_valid=1, m_data is held stable until pop.
- Simultaneous write and pop: occ unchanged, both pointers advance. Pointers wrap modulo 2.
- Throughput: with m_ready held 1 and the FIFO non-empty, one word per cycle after the initial latency, for either READ_LATENCY.
- Back-pressure with m_ready=0:
  - occ plus in-flight never exceeds 2; fifo_ren deasserts.
  - No word is dropped or duplicated.
- The FIFO is never read while fifo_empty=1, since fifo_ren requires !fifo_empty.
- flush=1 on an edge:
  - occ=0 and inflight=0.
  - Any data returning from an in-flight read is discarded.
  - m_valid=0 the next cycle.
  - flush has priority over a simultaneous write or pop.
  - FIFO contents are untouched apart from reads already issued.
- enable deassert mid-stream:
  - Reads already issued complete into the buffer.
  - The buffer drains normally.
  - busy stays 1 until occ=0 and inflight=0.
- Word order on m_data equals FIFO pop order.

Optional Feature:
SYNC_FIFO_READER_STATS_EN
- Defined: adds outputs words_out (32-bit, +1 per pop, wraps at 2^32) and stall_cycles (32-bit, +1 per cycle with m_valid & !m_ready, saturates at all-ones). Both are cleared by reset only, not by flush.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
1. Reset with READ_LATENCY=0, push 0x1111, 0x2222, 0x3333, m_ready=1 -> m_data sequence 0x1111, 0x2222, 0x3333 on consecutive cycles, the first one cycle after the first fifo_ren; busy falls after the last pop.
2. READ_LATENCY=1, 8 words pushed, m_ready=1 -> first m_valid 2 cycles after the first ren, then 8 valid cycles back-to-back with no gaps.
3. m_ready=0 for 10 cycles with 8 words queued -> exactly 2 fifo_ren pulses (3 for READ_LATENCY=1 is a failure). Release m_ready -> all 8 words appear in order, none duplicated.
4. Random m_ready (50%) over 200 random 64-bit words compared against a scoreboard queue -> zero mismatches; fifo_ren never 1 while fifo_empty=1.
5. Assert flush with occ=2 and a read in flight (READ_LATENCY=1) -> m_valid=0 next cycle; the next word delivered is the FIFO's next unread entry.
6. Drive reset low mid-stream with m_valid=1 -> m_valid, fifo_ren and busy are 0 immediately (asynchronous). With SYNC_FIFO_READER_STATS_EN defined, words_out and stall_cycles read 0 after reset and match scoreboard counts after test 4.
